// File: rtl/bist_sequencer.sv
`timescale 1ns/1ps
// rtl/bist_sequencer.sv - run controller for the bus-invert encode/decode self-test datapath
module bist_sequencer #(
  parameter int N_SAMPLES  = 2000,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             err_en,
  input  logic             isequal,
  output logic             en_gen_data,
  output logic             en_gen_err,
  output logic             en_enc,
  output logic             en_bus,
  output logic             en_dec,
  output logic             en_trans_count,
  output logic             en_bf1,
  output logic             en_bf2,
  output logic             en_k_comp,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count,
  output logic             pass
);

  // drain counter runs 0 .. PIPE_DEPTH-1
  localparam int DRN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SAMP_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] SAMP_TOTAL = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] SAMP_KCOMP = CNT_W'(PIPE_DEPTH);
  localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             pass_q, pass_d;

  logic en_gen_data_q, en_gen_data_d;
  logic en_gen_err_q, en_gen_err_d;
  logic en_pipe_q, en_pipe_d;
  logic en_trans_q, en_trans_d;
  logic en_k_comp_q, en_k_comp_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic start_ok;
  logic abort_run;

  assign start_ok  = (state_q == S_IDLE) && start && !abort;
  assign abort_run = (state_q != S_IDLE) && abort;

  // next state and in-run position counters; abort overrides every transition
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    drn_d   = drn_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RUN;
        samp_d  = '0;
      end
      S_RUN: begin
        if (samp_q == SAMP_LAST) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = S_DONE;
        else                   drn_d   = drn_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // output decode of the upcoming state, so every output leaves a flop
  always_comb begin
    en_gen_data_d = (state_d == S_LOAD) || (state_d == S_RUN);
    en_gen_err_d  = (state_d == S_RUN) && err_en;
    en_pipe_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    en_trans_d    = (state_d == S_RUN);
    en_k_comp_d   = ((state_d == S_RUN) && (samp_d >= SAMP_KCOMP)) || (state_d == S_DRAIN);
    done_d        = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  // saturating comparison/error counters and the run verdict
  always_comb begin
    err_d  = err_q;
    cmp_d  = cmp_q;
    pass_d = pass_q;
    if (start_ok) begin
      err_d  = '0;
      cmp_d  = '0;
      pass_d = 1'b0;
    end else if (abort_run) begin
      pass_d = 1'b0;
    end else begin
      if (en_k_comp_q) begin
        if (cmp_q != CNT_MAX) cmp_d = cmp_q + 1'b1;
        if (!isequal && (err_q != CNT_MAX)) err_d = err_q + 1'b1;
      end
      if (state_q == S_DONE) pass_d = (err_q == '0) && (cmp_q == SAMP_TOTAL);
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      samp_q        <= '0;
      drn_q         <= '0;
      err_q         <= '0;
      cmp_q         <= '0;
      pass_q        <= 1'b0;
      en_gen_data_q <= 1'b0;
      en_gen_err_q  <= 1'b0;
      en_pipe_q     <= 1'b0;
      en_trans_q    <= 1'b0;
      en_k_comp_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_q        <= samp_d;
      drn_q         <= drn_d;
      err_q         <= err_d;
      cmp_q         <= cmp_d;
      pass_q        <= pass_d;
      en_gen_data_q <= en_gen_data_d;
      en_gen_err_q  <= en_gen_err_d;
      en_pipe_q     <= en_pipe_d;
      en_trans_q    <= en_trans_d;
      en_k_comp_q   <= en_k_comp_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign en_gen_data    = en_gen_data_q;
  assign en_gen_err     = en_gen_err_q;
  assign en_enc         = en_pipe_q;
  assign en_bus         = en_pipe_q;
  assign en_dec         = en_pipe_q;
  assign en_trans_count = en_trans_q;
  assign en_bf1         = 1'b0;
  assign en_bf2         = 1'b0;
  assign en_k_comp      = en_k_comp_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign err_count      = err_q;
  assign cmp_count      = cmp_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_bist_sequencer.sv
`timescale 1ns/1ps
// tb/tb_bist_sequencer.sv - self-checking bench for bist_sequencer
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start_s[2];
  logic abort_s[2];
  logic err_en_s[2];
  logic isequal_s[2];

  logic w_gen[2], w_gerr[2], w_enc[2], w_bus[2], w_dec[2], w_tc[2];
  logic w_bf1[2], w_bf2[2], w_kc[2], w_done[2], w_busy[2], w_pass[2];
  logic [10:0] errc_a, cmpc_a;
  logic [2:0]  errc_b, cmpc_b;

  always #5 clk = ~clk;

  bist_sequencer #(.N_SAMPLES(16), .PIPE_DEPTH(4), .CNT_W(11)) dut_a (
    .clk(clk), .rst(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .err_en(err_en_s[0]), .isequal(isequal_s[0]),
    .en_gen_data(w_gen[0]), .en_gen_err(w_gerr[0]), .en_enc(w_enc[0]),
    .en_bus(w_bus[0]), .en_dec(w_dec[0]), .en_trans_count(w_tc[0]),
    .en_bf1(w_bf1[0]), .en_bf2(w_bf2[0]), .en_k_comp(w_kc[0]),
    .done(w_done[0]), .busy(w_busy[0]), .err_count(errc_a),
    .cmp_count(cmpc_a), .pass(w_pass[0])
  );

  bist_sequencer #(.N_SAMPLES(7), .PIPE_DEPTH(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .err_en(err_en_s[1]), .isequal(isequal_s[1]),
    .en_gen_data(w_gen[1]), .en_gen_err(w_gerr[1]), .en_enc(w_enc[1]),
    .en_bus(w_bus[1]), .en_dec(w_dec[1]), .en_trans_count(w_tc[1]),
    .en_bf1(w_bf1[1]), .en_bf2(w_bf2[1]), .en_k_comp(w_kc[1]),
    .done(w_done[1]), .busy(w_busy[1]), .err_count(errc_b),
    .cmp_count(cmpc_b), .pass(w_pass[1])
  );

  // run-position model: mp = cycles since the LOAD cycle, -1 when idle
  int mp[2];
  int mcmp[2];
  int merr[2];
  bit mpass[2];

  function automatic int nn(input int i);
    return (i == 0) ? 16 : 7;
  endfunction

  function automatic int smax(input int i);
    return (i == 0) ? 2047 : 7;
  endfunction

  localparam int PD = 4;

  function automatic bit kc_at(input int i, input int p);
    return (p >= PD + 1) && (p <= nn(i) + PD);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mp[i]    <= -1;
        mcmp[i]  <= 0;
        merr[i]  <= 0;
        mpass[i] <= 1'b0;
      end else if (mp[i] >= 0 && abort_s[i]) begin
        mp[i]    <= -1;
        mpass[i] <= 1'b0;
      end else if (mp[i] < 0) begin
        if (start_s[i] && !abort_s[i]) begin
          mp[i]    <= 0;
          mcmp[i]  <= 0;
          merr[i]  <= 0;
          mpass[i] <= 1'b0;
        end
      end else begin
        if (kc_at(i, mp[i])) begin
          if (mcmp[i] < smax(i)) mcmp[i] <= mcmp[i] + 1;
          if (!isequal_s[i] && merr[i] < smax(i)) merr[i] <= merr[i] + 1;
        end
        if (mp[i] == nn(i) + PD + 1) begin
          mpass[i] <= (merr[i] == 0) && (mcmp[i] == nn(i));
          mp[i]    <= -1;
        end else begin
          mp[i] <= mp[i] + 1;
        end
      end
    end
  end

  // flags: {busy,done,pass,gen,gerr,enc,bus,dec,tc,bf1,bf2,kc}
  function automatic logic [11:0] exp_flags(input int i);
    int  p;
    bit  run, pipe;
    p    = mp[i];
    run  = (p >= 1) && (p <= nn(i));
    pipe = (p >= 1) && (p <= nn(i) + PD);
    return {p >= 0, p == nn(i) + PD + 1, mpass[i], (p >= 0) && (p <= nn(i)),
            run && err_en_s[i], pipe, pipe, pipe, run, 1'b0, 1'b0, kc_at(i, p)};
  endfunction

  function automatic logic [11:0] act_flags(input int i);
    return {w_busy[i], w_done[i], w_pass[i], w_gen[i], w_gerr[i], w_enc[i],
            w_bus[i], w_dec[i], w_tc[i], w_bf1[i], w_bf2[i], w_kc[i]};
  endfunction

  int vectors = 0;
  int fails   = 0;

  int n_cyc, n_busy, n_kc, n_done, n_gen_rise, gen_idx, kc_idx, done_idx;
  logic gen_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic clr_mon();
    n_cyc = 0; n_busy = 0; n_kc = 0; n_done = 0; n_gen_rise = 0;
    gen_idx = -1; kc_idx = -1; done_idx = -1;
  endtask

  // one run on instance A; isequal forced 0 at positions in zmask, abort at position abort_at
  task automatic run_a(input logic [31:0] zmask, input int abort_at);
    start_s[0] = 1'b1;
    @(posedge clk); #2;
    start_s[0] = 1'b0;
    for (int p = 0; p <= 21; p++) begin
      isequal_s[0] = !zmask[p];
      abort_s[0]   = (p == abort_at);
      @(posedge clk); #2;
    end
    isequal_s[0] = 1'b1;
    abort_s[0]   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; err_en_s[i] = 1'b0; isequal_s[i] = 1'b1;
    end
    clr_mon();

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (act_flags(i) !== exp_flags(i)) begin
            fails++;
            $display("FAIL flags[%0d] at %0t actual=%b required=%b", i, $time, act_flags(i), exp_flags(i));
          end
          vectors++;
          if ((i == 0 && (int'(errc_a) != merr[0] || int'(cmpc_a) != mcmp[0])) ||
              (i == 1 && (int'(errc_b) != merr[1] || int'(cmpc_b) != mcmp[1]))) begin
            fails++;
            $display("FAIL counts[%0d] at %0t actual err/cmp=%0d/%0d required=%0d/%0d", i, $time,
                     (i == 0) ? int'(errc_a) : int'(errc_b), (i == 0) ? int'(cmpc_a) : int'(cmpc_b),
                     merr[i], mcmp[i]);
          end
        end
        n_cyc++;
        if (w_busy[0]) n_busy++;
        if (w_kc[0]) begin n_kc++; if (kc_idx < 0) kc_idx = n_cyc; end
        if (w_done[0]) begin n_done++; if (done_idx < 0) done_idx = n_cyc; end
        if (w_gen[0] && !gen_prev) begin n_gen_rise++; if (gen_idx < 0) gen_idx = n_cyc; end
        gen_prev = w_gen[0];
      end
    join_none

    repeat (2) @(posedge clk);
    #2;
    chk("reset_flags_a", int'(act_flags(0)), 0);
    chk("reset_err_a", int'(errc_a), 0);
    chk("reset_cmp_a", int'(cmpc_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // clean run with error generator enabled
    err_en_s[0] = 1'b1;
    clr_mon();
    run_a(32'h0, -1);
    chk("t1_busy_cycles", n_busy, 22);
    chk("t1_kcomp_cycles", n_kc, 16);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_done_offset", done_idx - gen_idx, 21);
    chk("t1_kcomp_first", kc_idx - gen_idx, 5);
    chk("t1_err", int'(errc_a), 0);
    chk("t1_cmp", int'(cmpc_a), 16);
    chk("t1_pass", int'(w_pass[0]), 1);
    chk("t1_model_cmp", mcmp[0], 16);

    // three mismatches inside the compare window, two outside
    run_a((32'h1 << 6) | (32'h1 << 10) | (32'h1 << 20) | (32'h1 << 2) | (32'h1 << 21), -1);
    chk("t2_err", int'(errc_a), 3);
    chk("t2_cmp", int'(cmpc_a), 16);
    chk("t2_pass", int'(w_pass[0]), 0);
    chk("t2_model_err", merr[0], 3);

    // abort in RUN at sample counter 7, then a normal run
    clr_mon();
    run_a(32'h0, 8);
    chk("t3_done_pulses", n_done, 0);
    chk("t3_pass", int'(w_pass[0]), 0);
    chk("t3_cmp_held", int'(cmpc_a), 3);
    chk("t3_busy_cycles", n_busy, 9);
    run_a(32'h0, -1);
    chk("t3_rerun_pass", int'(w_pass[0]), 1);

    // asynchronous reset between edges during DRAIN
    start_s[0] = 1'b1;
    @(posedge clk); #2;
    start_s[0] = 1'b0;
    repeat (18) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t4_flags_async", int'(act_flags(0)), 0);
    chk("t4_err_async", int'(errc_a), 0);
    chk("t4_cmp_async", int'(cmpc_a), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("t4_idle_busy", int'(w_busy[0]), 0);
    run_a(32'h0, -1);
    chk("t4_rerun_pass", int'(w_pass[0]), 1);

    // start held high: back-to-back runs
    clr_mon();
    start_s[0] = 1'b1;
    repeat (46) @(posedge clk);
    #2;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t5_done_pulses", n_done, 2);
    chk("t5_gen_rises", n_gen_rise, 2);
    chk("t5_busy_cycles", n_busy, 44);
    chk("t5_pass", int'(w_pass[0]), 1);

    // narrow counters, every comparison mismatches
    isequal_s[1] = 1'b0;
    start_s[1]   = 1'b1;
    @(posedge clk); #2;
    start_s[1] = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("t6_err", int'(errc_b), 7);
    chk("t6_cmp", int'(cmpc_b), 7);
    chk("t6_pass", int'(w_pass[1]), 0);
    chk("t6_model_err", merr[1], 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Run controller for the bus-invert encode/decode test datapath.
- On `start`, it sequences one self-test run:
  - seed the data generator,
  - stream `N_SAMPLES` words through encoder, bus, decoder and transition counter,
  - drain the compare pipeline,
  - pulse `done` so the transition counter publishes its histogram.
- Counts decoder/original mismatches reported by the datapath's k-bit comparator and produces a pass/fail verdict.
- Sits beside the datapath and drives all of its enables.

Parameters:
N_SAMPLES, 2000, words streamed per run; legal range PIPE_DEPTH+1 .. 2^CNT_W-1
PIPE_DEPTH, 4, cycles from encoder input to comparator-valid; equals the datapath compare delay line depth
CNT_W, 11, width of sample and error counters

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level; sampled only in IDLE
abort  in  1  synchronous abort, any state
err_en  in  1  enables error generator during RUN
isequal  in  1  comparator result from datapath
en_gen_data  out  1  data generator enable (rising edge reloads seed)
en_gen_err  out  1  error generator enable
en_enc  out  1  encoder enable
en_bus  out  1  bus pass enable
en_dec  out  1  decoder enable
en_trans_count  out  1  transition counter enable
en_bf1  out  1  reserved; held 0
en_bf2  out  1  reserved; held 0
en_k_comp  out  1  comparator result valid
done  out  1  one-cycle end-of-run pulse
busy  out  1  high in every state except IDLE
err_count  out  CNT_W  mismatches counted this run
cmp_count  out  CNT_W  comparisons performed this run
pass  out  1  verdict of last completed run

Behaviour:
- All outputs are registered: Moore decode of state and counters.
- Reset (`rst`=0), asynchronous, any time including mid-run:
  - state IDLE;
  - all enables, `done`, `busy` and `pass` are 0;
  - `err_count` and `cmp_count` are 0.
- States and cycle behaviour (cycle L = first cycle in LOAD):
  - IDLE:
    - enables 0, `busy`=0.
    - `start`=1 moves to LOAD next cycle and clears `err_count`, `cmp_count` and `pass`.
  - LOAD: 1 cycle.
    - `en_gen_data`=1, `busy`=1; other enables 0.
    - Moves to RUN.
  - RUN: exactly N_SAMPLES cycles, L+1 .. L+N_SAMPLES.
    - `en_gen_data`, `en_enc`, `en_bus`, `en_dec`, `en_trans_count` are 1.
    - `en_gen_err` = `err_en`.
    - A sample counter counts RUN cycles from 0.
    - `en_k_comp`=1 when sample counter >= PIPE_DEPTH.
    - After the cycle with sample counter = N_SAMPLES-1, moves to DRAIN.
  - DRAIN: exactly PIPE_DEPTH cycles.
    - `en_gen_data`, `en_gen_err`, `en_trans_count` are 0.
    - `en_enc`, `en_bus`, `en_dec`, `en_k_comp` are 1.
    - Moves to DONE.
  - DONE: 1 cycle.
    - `done`=1, `busy`=1, all enables 0.
    - `pass` is loaded with (`err_count`==0 and `cmp_count`==N_SAMPLES).
    - Moves to IDLE.
- Run totals: total comparisons per run = N_SAMPLES. Total busy cycles = N_SAMPLES + PIPE_DEPTH + 2.
- Counting:
  - Each cycle with `en_k_comp`=1: `cmp_count` +1.
  - If additionally `isequal`=0: `err_count` +1.
  - Both counters saturate at 2^CNT_W-1.
  - Counters update on the edge ending the cycle, so the DONE-cycle value is final.
- `err_count`, `cmp_count` and `pass` hold their values in IDLE until the next accepted `start`.
- `start` while `busy` is ignored. No queuing.
- `abort`=1 in any non-IDLE state:
  - next state IDLE, all enables 0;
  - no `done` pulse;
  - `pass`=0;
  - counters hold.
  - `abort` has priority over all transitions, including DONE→IDLE: `done` still shows its already-registered value that cycle, but `pass` is forced 0.
- `abort` and `start` both high in IDLE: `abort` wins, stay IDLE.
- `en_gen_data` falls to 0 for at least one cycle (DRAIN/DONE/IDLE) between runs, guaranteeing a seed-reload rising edge on the next LOAD.

Test Plan:
1. N_SAMPLES=16, PIPE_DEPTH=4, `isequal` tied 1, `start` pulse:
   - `busy` high 22 cycles;
   - `en_k_comp` high 16 cycles, from RUN cycle 4 through end of DRAIN;
   - `done` one pulse at cycle L+21;
   - `err_count`=0, `cmp_count`=16, `pass`=1.
2. Same setup, `isequal` forced 0 on 3 `en_k_comp` cycles and 0 on 2 cycles outside `en_k_comp` → `err_count`=3, `pass`=0.
3. `abort` asserted in RUN at sample counter 7:
   - next cycle IDLE, all enables 0, no `done`, `pass`=0;
   - a following `start` completes a normal run with `pass`=1.
4. `rst` asserted low mid-DRAIN (asynchronous, between edges) → all outputs 0 immediately, with no clock edge; after release, state is IDLE.
5. `start` held high continuously:
   - back-to-back runs with exactly one IDLE cycle between DONE and LOAD;
   - `en_gen_data` low between runs, then high in each LOAD.
6. CNT_W=3, N_SAMPLES=7, PIPE_DEPTH=4, `isequal`=0 throughout → `err_count`=7 (saturation limit reached, no wrap), `cmp_count`=7, `pass`=0.
